// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if
// Groups every non-clock signal of the burst controller into one bundle.
// Parameters mirror the controller: DATA_WIDTH (RAM word), ADDR_WIDTH (RAM
// address), LEN_WIDTH (burst length field, beats = cmd_len + 1).
// Modports:
//   slave  - the controller: takes commands/write beats and RAM read data,
//            drives ready/valid/done and both RAM ports.
//   master - the environment: command source, write-data source, read-data
//            sink and the RAM itself.
interface ram_burst_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata;

    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  done;

    logic                  ram_port_en_0;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_addr_0;
    logic [DATA_WIDTH-1:0] ram_data_in;

    logic                  ram_port_en_1;
    logic [ADDR_WIDTH-1:0] ram_addr_1;
    logic [DATA_WIDTH-1:0] ram_data_out_1;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wdata_valid, wdata,
        input  ram_data_out_1,
        output cmd_ready, wdata_ready, rdata_valid, rdata, done,
        output ram_port_en_0, ram_wr_en, ram_addr_0, ram_data_in,
        output ram_port_en_1, ram_addr_1
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wdata_valid, wdata,
        output ram_data_out_1,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, done,
        input  ram_port_en_0, ram_wr_en, ram_addr_0, ram_data_in,
        input  ram_port_en_1, ram_addr_1
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Turns single burst commands into per-beat accesses on a dual-port RAM.
// Write bursts stream beats from the wdata handshake straight onto write
// port 0; read bursts issue one address per cycle on port 1 and return the
// data (RAM latency 1) on rdata with no backpressure.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ram_burst_ctrl_if.slave: command, write-data, read-data, done
//          and both RAM ports
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high (from the first edge after reset)
// WRITE | accepting write beats, one RAM write per accepted beat
// READ  | issuing one RAM read per cycle for cmd_len+1 cycles
// DRAIN | final read data returning, done pulses here
module ram_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    ram_burst_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  beats_left;   // remaining beats minus one, terminal count at 0
    logic                  rdy;
    logic                  done_q;
    logic                  rvalid;
    logic                  wr_beat;
    logic                  rd_issue;

    assign wr_beat  = (state == WRITE) && bus.wdata_valid;
    assign rd_issue = (state == READ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            beats_left <= '0;
            rdy        <= 1'b0;
            done_q     <= 1'b0;
            rvalid     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rvalid <= rd_issue;
            case (state)
                IDLE: begin
                    rdy <= 1'b1;
                    if (bus.cmd_valid && rdy) begin
                        addr       <= bus.cmd_addr;
                        beats_left <= bus.cmd_len;
                        rdy        <= 1'b0;
                        state      <= bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        addr <= addr + ADDR_WIDTH'(1);
                        if (beats_left == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                            rdy    <= 1'b1;
                        end else begin
                            beats_left <= beats_left - LEN_WIDTH'(1);
                        end
                    end
                end
                READ: begin
                    addr <= addr + ADDR_WIDTH'(1);
                    if (beats_left == '0) begin
                        // last data returns during DRAIN, so done is raised with it
                        state  <= DRAIN;
                        done_q <= 1'b1;
                    end else begin
                        beats_left <= beats_left - LEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = rdy;
    assign bus.wdata_ready = (state == WRITE);
    assign bus.done        = done_q;

    // write port follows the beat handshake combinationally, zero otherwise
    assign bus.ram_port_en_0 = wr_beat;
    assign bus.ram_wr_en     = wr_beat;
    assign bus.ram_addr_0    = wr_beat ? addr : '0;
    assign bus.ram_data_in   = wr_beat ? bus.wdata : '0;

    assign bus.ram_port_en_1 = rd_issue;
    assign bus.ram_addr_1    = rd_issue ? addr : '0;

    // RAM output is already one cycle behind the issue, so it only needs gating
    assign bus.rdata_valid = rvalid;
    assign bus.rdata       = rvalid ? bus.ram_data_out_1 : '0;

endmodule
